// File: rtl/mac_psum_accum.sv
// Shift-accumulates NUM_PLANES bit-plane partial sums (MSB plane first) into one signed dot product.
// Result registered 1 cycle after the last-plane accept; in_ready drops only on the last plane while the output is blocked.
module mac_psum_accum #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PLANES = 8,
    parameter int ACC_WIDTH  = 19,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clr,
    input  logic                                 cfg_signed,
    input  logic                                 in_valid,
    input  logic signed [DATA_WIDTH+2:0]         in_psum,
    output logic                                 in_ready,
    output logic                                 out_valid,
    output logic signed [ACC_WIDTH-1:0]          out_data,
    input  logic                                 out_ready,
    output logic [$clog2(NUM_PLANES)-1:0]        plane_idx,
    output logic [CNT_WIDTH-1:0]                 group_cnt
);

    localparam int PSUM_W = DATA_WIDTH + 3;
    localparam int IDX_W  = $clog2(NUM_PLANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLANES - 1);

    if (NUM_PLANES < 2) begin : g_bad_planes
        $error("mac_psum_accum: NUM_PLANES must be at least 2");
    end
    if (ACC_WIDTH < PSUM_W + NUM_PLANES) begin : g_bad_acc
        $error("mac_psum_accum: ACC_WIDTH too narrow for PSUM_W + NUM_PLANES");
    end

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] psum_x;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic                        last_plane;
    logic                        acc_fire;

    assign psum_x     = {{(ACC_WIDTH-PSUM_W){in_psum[PSUM_W-1]}}, in_psum};
    assign acc_next   = (acc <<< 1) + psum_x;
    assign last_plane = (plane_idx == LAST_IDX);
    assign in_ready   = !reset && !clr && (!last_plane || !out_valid || out_ready);
    assign acc_fire   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            plane_idx <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            group_cnt <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            if (clr) begin
                acc       <= '0;
                plane_idx <= '0;
            end else if (acc_fire) begin
                if (plane_idx == '0) begin
                    // Two's-complement weights: the MSB plane carries -2^(N-1), so negate it up front.
                    acc       <= cfg_signed ? -psum_x : psum_x;
                    plane_idx <= IDX_W'(1);
                end else if (last_plane) begin
                    out_data  <= acc_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    plane_idx <= '0;
                    group_cnt <= group_cnt + 1'b1;
                end else begin
                    acc       <= acc_next;
                    plane_idx <= plane_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_psum_accum.sv
// Directed bench for mac_psum_accum with an expected-result queue drained by an output monitor.
module tb_mac_psum_accum;

    typedef logic signed [10:0] psum_t;
    typedef psum_t planes_t [8];

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               clr = 1'b0;
    logic               cfg_signed = 1'b1;
    logic               in_valid = 1'b0;
    psum_t              in_psum = '0;
    logic               in_ready;
    logic               out_valid;
    logic signed [18:0] out_data;
    logic               out_ready = 1'b1;
    logic [2:0]         plane_idx;
    logic [15:0]        group_cnt;

    int vectors = 0;
    int errs    = 0;
    logic signed [31:0] exp_q [$];

    mac_psum_accum dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .cfg_signed(cfg_signed),
        .in_valid  (in_valid),
        .in_psum   (in_psum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .plane_idx (plane_idx),
        .group_cnt (group_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: weighted sum of planes, MSB plane weight negated for signed weights.
    function automatic logic signed [31:0] model(input planes_t p, input logic sgn);
        logic signed [31:0] r;
        logic signed [31:0] w;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            w = 32'sd1 <<< (7 - i);
            if (i == 0 && sgn) w = -w;
            r = r + 32'(p[i]) * w;
        end
        return r;
    endfunction

    // Output monitor: every output handshake consumes one expected result.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errs++;
                $error("FAIL spurious_out: observed %0d expected none", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input psum_t p, input logic sgn);
        int n;
        n = 0;
        cfg_signed = sgn;
        in_psum    = p;
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 100, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic group(input planes_t p, input logic sgn);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_q.push_back(model(p, sgn));
            send(p[i], sgn);
        end
    endtask

    function automatic planes_t fill(input psum_t first, input psum_t rest);
        planes_t p;
        p[0] = first;
        for (int i = 1; i < 8; i++) p[i] = rest;
        return p;
    endfunction

    initial begin
        planes_t p;
        int n;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_group_cnt", group_cnt, 0);
        chk("rst_plane_idx", plane_idx, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Signed all-ones group: -128 + 127 = -1, one-cycle valid pulse.
        group(fill(11'sd1, 11'sd1), 1'b1);
        @(negedge clk);
        chk("t1_valid_rise", out_valid, 1);
        chk("t1_group_cnt", group_cnt, 1);
        chk("t1_plane_idx", plane_idx, 0);
        @(negedge clk);
        chk("t1_valid_fall", out_valid, 0);
        @(posedge clk); #1;

        // Extreme psums, back to back.
        group(fill(-11'sd1024, -11'sd1024), 1'b0);
        group(fill(-11'sd1024, -11'sd1024), 1'b1);
        group(fill(-11'sd1024, 11'sd1016), 1'b1);
        @(negedge clk);
        chk("arith_last_data", out_data, 260104);
        chk("arith_group_cnt", group_cnt, 4);
        @(posedge clk); #1;

        // Back-pressure: group A blocked, group B stalls at its last plane.
        out_ready = 1'b0;
        group(fill(11'sd1, 11'sd1), 1'b1);
        // cfg_signed deasserted only on plane 0, so group B is unsigned: 255.
        send(11'sd1, 1'b0);
        for (int i = 1; i < 7; i++) send(11'sd1, 1'b1);
        exp_q.push_back(32'sd255);
        cfg_signed = 1'b1;
        in_psum    = 11'sd1;
        in_valid   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_hold_data", out_data, -1);
            chk("bp_plane_idx", plane_idx, 7);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_release", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("bp_b2b_valid", out_valid, 1);
        chk("bp_b2b_data", out_data, 255);
        chk("bp_group_cnt", group_cnt, 6);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // clr mid-group with a pending result.
        out_ready = 1'b0;
        group(fill(11'sd1, 11'sd1), 1'b1);
        for (int i = 0; i < 3; i++) send(11'sd7, 1'b1);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_psum  = 11'sd9;
        @(negedge clk);
        chk("clr_in_ready", in_ready, 0);
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_plane_idx", plane_idx, 0);
        chk("clr_pending_valid", out_valid, 1);
        chk("clr_pending_data", out_data, -1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        group(fill(11'sd2, 11'sd2), 1'b1);
        @(negedge clk);
        chk("clr_group_cnt", group_cnt, 8);
        @(posedge clk); #1;

        // Bubbles between every plane.
        p = fill(11'sd0, 11'sd0);
        p[7] = 11'sd5;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_q.push_back(model(p, 1'b1));
            send(p[i], 1'b1);
            if (i < 7) begin
                @(negedge clk);
                chk("bub_plane_idx", plane_idx, i + 1);
                @(posedge clk); #1;
                @(negedge clk);
                chk("bub_plane_hold", plane_idx, i + 1);
                @(posedge clk); #1;
            end
        end

        // Reset mid-group drops the pending result.
        @(posedge clk); #1;
        out_ready = 1'b0;
        group(fill(11'sd1, 11'sd1), 1'b1);
        for (int i = 0; i < 4; i++) send(11'sd3, 1'b1);
        @(negedge clk);
        chk("prerst_plane_idx", plane_idx, 4);
        chk("prerst_valid", out_valid, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_group_cnt", group_cnt, 0);
        chk("mrst_plane_idx", plane_idx, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        group(fill(11'sd1, 11'sd1), 1'b1);
        @(negedge clk);
        chk("post_rst_data", out_data, -1);
        chk("post_rst_group_cnt", group_cnt, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/mac_psum_accum.md
Name: mac_psum_accum

Overview:
- Downstream neighbour of the 8-lane adder-tree MAC unit in the bit-serial datapath.
- Consumes one 11-bit signed partial sum per weight bit-plane, MSB plane first.
- Shift-accumulates NUM_PLANES planes into one full-precision dot-product result.
- Presents that result on a valid/ready output port and back-pressures the array controller only when the output is blocked.

Parameters:
- DATA_WIDTH, 8: activation width of the upstream MAC. Partial-sum width PSUM_W = DATA_WIDTH+3.
- NUM_PLANES, 8: weight bit-planes per group (weight precision). Must be ≥ 2.
- ACC_WIDTH, 19: accumulator and result width. Must be ≥ PSUM_W+NUM_PLANES.
- CNT_WIDTH, 16: width of the emitted-group counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- clr, input, 1: synchronous flush of the in-progress group.
- cfg_signed, input, 1: 1 = two's-complement weights (MSB plane carries negative weight); 0 = unsigned weights.
- in_valid, input, 1: in_psum is valid this cycle. Issued by the controller aligned to the MAC's 2-cycle latency.
- in_psum, input, PSUM_W: signed partial sum from the MAC.
- in_ready, output, 1: block accepts in_psum this cycle.
- out_valid, output, 1: out_data holds a completed group.
- out_data, output, ACC_WIDTH: signed group result.
- out_ready, input, 1: consumer takes out_data.
- plane_idx, output, clog2(NUM_PLANES): index of the next plane expected. 0 means MSB plane.
- group_cnt, output, CNT_WIDTH: groups emitted since reset.

Behaviour:
- Reset (sync, has priority over everything): acc=0, plane_idx=0, sign_q=0, out_valid=0, out_data=0, group_cnt=0.
- Accept condition: acc_fire = in_valid && in_ready.
- in_ready:
  - is 1 whenever plane_idx != NUM_PLANES-1;
  - on the last plane, is (!out_valid || out_ready);
  - is 0 during reset and in a cycle with clr=1.
- Sign extension: psum_x = in_psum sign-extended to ACC_WIDTH.
- Plane 0 accept:
  - sign_q <= cfg_signed;
  - acc <= cfg_signed ? -psum_x : psum_x;
  - plane_idx <= 1.
  - cfg_signed is sampled only here and is held for the whole group.
- Middle plane accept (0 < plane_idx < NUM_PLANES-1): acc <= (acc <<< 1) + psum_x; plane_idx++.
- Last plane accept:
  - out_data <= (acc <<< 1) + psum_x;
  - out_valid <= 1;
  - acc <= 0;
  - plane_idx <= 0;
  - group_cnt++ (wraps modulo 2^CNT_WIDTH).
- Latency: result appears on out_data/out_valid the cycle after the last-plane accept.
- Throughput: one group per NUM_PLANES cycles, with no bubble between groups.
- Output handshake:
  - out_valid is cleared on out_ready && out_valid, unless a new last-plane accept happens in the same cycle. In that case out_valid stays 1 and out_data is replaced (back-to-back).
  - out_data is stable while out_valid && !out_ready.
- in_valid while in_ready=0: the input is ignored and not accepted. The controller must hold it.
- clr:
  - acc <= 0, plane_idx <= 0, and any input this cycle is discarded;
  - the output register (out_valid/out_data) and group_cnt are unaffected, so a pending result is still delivered.
- Arithmetic: the ACC_WIDTH bound guarantees no overflow for any psum in [-2^(PSUM_W-1), 2^(PSUM_W-1)-1]. No saturation logic.
- Gaps: in_valid may drop mid-group for any number of cycles; acc and plane_idx hold.
- Reset mid-group: the partial group is lost and out_valid drops immediately, with no pending result delivered.

Test Plan:
- Signed, all eight planes psum=1, out_ready=1 → out_data = -128+127 = -1, out_valid for 1 cycle, 9th cycle after first accept, group_cnt=1.
- Unsigned (cfg_signed=0), all planes psum=-1024 → out_data = -261120. Signed, all planes psum=-1024 → out_data = 1024. Signed, plane0=-1024, planes1-7=1016 → out_data = 260104. No overflow in any case.
- Back-pressure: out_ready=0 after group 1 completes, group 2 streamed →
  - in_ready=0 at plane 7 of group 2 with in_valid held;
  - out_data holds group 1 value;
  - out_ready=1 for one cycle → group 1 taken, plane 7 of group 2 accepted that same cycle;
  - group 2 appears next cycle.
- clr asserted after 3 planes with out_valid=1 pending → pending result still handshakes; plane_idx=0; next 8 planes of psum=2 give out_data=-2.
- Bubbles: in_valid toggling 1/0 across 16 cycles, signed planes [0,0,0,0,0,0,0,5] → out_data=5 after 8th accept; plane_idx holds on idle cycles.
- Sync reset at plane 4 with out_valid=1 → all outputs 0 next cycle; fresh group of psum=1 yields -1.
